// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Pipeline stall/flush sequencer for the 5-stage core. Each cycle it decides
// whether the front end advances, stalls one cycle for a load-use hazard,
// freezes the whole pipeline while data memory is busy, or flushes the
// wrong-path instructions behind a taken branch. Control outputs are Mealy
// (state + current inputs, zero latency). A long memory wait latches a
// sticky timeout that only reset clears.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the performance counters.
// Without it the counter ports read 0 and no counter flops exist.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   Rn_ID, Rm_ID, RnUsed_ID,
//   RmUsed_ID                     ID-stage source registers and their use flags
//   Rd_EX, MemRead_EX             EX-stage destination and load flag
//   BranchTaken_MEM               branch resolved taken in MEM
//   dmem_req, dmem_ready          data memory handshake for the MEM stage
//   PCWrite, IFID_Write           front-end enables
//   IDEX_Bubble                   insert NOP controls into ID/EX
//   IFID_Flush, IDEX_Flush,
//   EXMEM_Flush                   clear pipeline registers
//   Freeze                        hold every pipeline register and the PC
//   mem_timeout                   sticky memory timeout error
//   state_o                       FSM state (debug)
//   stall_cycles, freeze_cycles,
//   flush_events                  performance counters
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal flow; hazard priority decides the outputs
// MEM_WAIT | data memory busy; wait_cnt counts freeze cycles
// TIMEOUT  | memory never answered; pipeline frozen until reset
// (3)      | illegal; behaves like RUN and returns to RUN next clock

module hazard_sequencer #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             RnUsed_ID,
    input  logic             RmUsed_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             MemRead_EX,
    input  logic             BranchTaken_MEM,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             Freeze,
    output logic             mem_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_CNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  lu;
    logic                  mb;

    // XZR as destination never creates a dependency.
    assign lu = MemRead_EX && (Rd_EX != 5'd31) &&
                ((RnUsed_ID && (Rn_ID == Rd_EX)) || (RmUsed_ID && (Rm_ID == Rd_EX)));
    assign mb = dmem_req && !dmem_ready;

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IDEX_Bubble = 1'b0;
        IFID_Flush  = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        Freeze      = 1'b0;
        if (reset) begin
            // Reset looks like a full flush with a bubble so nothing
            // half-formed leaks out of the pipeline registers.
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (state == TIMEOUT || mb) begin
            Freeze     = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
        end else if (BranchTaken_MEM) begin
            // Any load-use hazard here is on the wrong path and gets flushed.
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (lu) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end
    end

    assign mem_timeout = (state == TIMEOUT);
    assign state_o     = reset ? 2'd0 : state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mb) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    // Leaving as soon as the access is no longer busy; a dropped
                    // request is treated the same as a completed one.
                    if (!mb) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt < WAIT_LIMIT) begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end else begin
                        state <= TIMEOUT;
                    end
                end
                TIMEOUT: begin
                    state <= TIMEOUT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Outside reset, IDEX_Bubble and IFID_Flush are only raised by the
    // load-use and branch paths, so they double as the event strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
            flush_events  <= '0;
        end else begin
            if (IDEX_Bubble) stall_cycles  <= stall_cycles + CNT_W'(1);
            if (Freeze)      freeze_cycles <= freeze_cycles + CNT_W'(1);
            if (IFID_Flush)  flush_events  <= flush_events + CNT_W'(1);
        end
    end
`else
    assign stall_cycles  = '0;
    assign freeze_cycles = '0;
    assign flush_events  = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    localparam int WT = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // ctrl = {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush,
    //         EXMEM_Flush, Freeze, mem_timeout}
    localparam logic [7:0] C_RUN   = 8'b1100_0000;
    localparam logic [7:0] C_STALL = 8'b0010_0000;
    localparam logic [7:0] C_FLUSH = 8'b1101_1100;
    localparam logic [7:0] C_FRZ   = 8'b0000_0010;
    localparam logic [7:0] C_TMO   = 8'b0000_0011;
    localparam logic [7:0] C_RST   = 8'b0011_1100;

    logic        clk, reset;
    logic [4:0]  Rn_ID, Rm_ID, Rd_EX;
    logic        RnUsed_ID, RmUsed_ID, MemRead_EX, BranchTaken_MEM;
    logic        dmem_req, dmem_ready;
    logic        PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush;
    logic        EXMEM_Flush, Freeze, mem_timeout;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles, freeze_cycles, flush_events;
    logic [7:0]  ctrl;

    int checks = 0;
    int errors = 0;

    hazard_sequencer #(.WAIT_TIMEOUT(WT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .RnUsed_ID(RnUsed_ID), .RmUsed_ID(RmUsed_ID),
        .Rd_EX(Rd_EX), .MemRead_EX(MemRead_EX), .BranchTaken_MEM(BranchTaken_MEM),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
        .Freeze(Freeze), .mem_timeout(mem_timeout), .state_o(state_o),
        .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles),
        .flush_events(flush_events)
    );

    assign ctrl = {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush,
                   EXMEM_Flush, Freeze, mem_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic memrd, input logic [4:0] rd, input logic [4:0] rn,
                          input logic rnu, input logic [4:0] rm, input logic rmu,
                          input logic br, input logic req, input logic rdy);
        MemRead_EX = memrd; Rd_EX = rd; Rn_ID = rn; RnUsed_ID = rnu;
        Rm_ID = rm; RmUsed_ID = rmu; BranchTaken_MEM = br;
        dmem_req = req; dmem_ready = rdy;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_cnts(input string tag, input int st, input int fr, input int fl);
        check_val({tag, "_stall"},  stall_cycles,  32'(st * PERF));
        check_val({tag, "_freeze"}, freeze_cycles, 32'(fr * PERF));
        check_val({tag, "_flush"},  flush_events,  32'(fl * PERF));
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        check_val("rst_ctrl", ctrl, C_RST);
        check_val("rst_state", state_o, 0);
        check_cnts("rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("run_ctrl", ctrl, C_RUN);
        tick();

        // load-use on Rn: one stall cycle
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lu_rn", ctrl, C_STALL);
        tick();
        idle();
        check_val("lu_clear", ctrl, C_RUN);
        check_cnts("lu", 1, 0, 0);

        // XZR destination never stalls
        set_in(1'b1, 5'd31, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("xzr", ctrl, C_RUN);
        tick();

        // Rm match only matters when Rm is read
        set_in(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rm_unused", ctrl, C_RUN);
        set_in(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rm_used", ctrl, C_STALL);
        tick();
        idle();
        check_cnts("rm", 2, 0, 0);

        // taken branch over an active load-use hazard
        set_in(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("br_lu", ctrl, C_FLUSH);
        tick();
        idle();
        check_cnts("br", 2, 0, 1);

        // memory busy 3 cycles then ready
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("mw_frz0", ctrl, C_FRZ);
        check_val("mw_st0", state_o, 0);
        tick();
        check_val("mw_frz1", ctrl, C_FRZ);
        check_val("mw_st1", state_o, 1);
        tick();
        check_val("mw_frz2", ctrl, C_FRZ);
        tick();
        dmem_ready = 1'b1;
        #1;
        check_val("mw_ready", ctrl, C_RUN);
        check_val("mw_st_rdy", state_o, 1);
        tick();
        idle();
        check_val("mw_back", state_o, 0);
        check_val("mw_ctrl", ctrl, C_RUN);
        check_cnts("mw", 2, 3, 1);

        // ready without request is ignored
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("rdy_noreq", ctrl, C_RUN);
        tick();
        check_val("rdy_noreq_st", state_o, 0);

        // busy memory beats a taken branch; flush follows on the ready cycle
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_val("mb_br", ctrl, C_FRZ);
        tick();
        dmem_ready = 1'b1;
        #1;
        check_val("mb_br_rdy", ctrl, C_FLUSH);
        tick();
        idle();
        check_val("mb_br_st", state_o, 0);
        check_cnts("mbbr", 2, 4, 2);

        // timeout: busy held past WT cycles
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < WT; i++) begin
            check_val($sformatf("to_wait%0d", i), ctrl, C_FRZ);
            tick();
        end
        check_val("to_pre_st", state_o, 1);
        check_val("to_pre_ctrl", ctrl, C_FRZ);
        tick();
        check_val("to_ctrl", ctrl, C_TMO);
        check_val("to_st", state_o, 2);
        dmem_req = 1'b0;
        #1;
        check_val("to_noreq", ctrl, C_TMO);
        tick();
        check_val("to_hold_st", state_o, 2);
        check_val("to_hold_ctrl", ctrl, C_TMO);
        check_cnts("to", 2, 10, 2);

        // reset mid-cycle clears everything immediately
        reset = 1'b1;
        #1;
        check_val("rp_ctrl", ctrl, C_RST);
        check_val("rp_st", state_o, 0);
        check_cnts("rp", 0, 0, 0);
        reset = 1'b0;
        #1;
        check_val("rp_run", ctrl, C_RUN);
        tick();
        check_val("rp_run2", ctrl, C_RUN);
        check_val("rp_st2", state_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline stall/flush sequencer for the 5-stage ARMv8 core, paired with the forwarding unit. Each cycle it decides whether the front end advances, stalls for a load-use hazard, freezes the whole pipeline while data memory is busy, or flushes wrong-path instructions after a taken branch. A small FSM tracks multi-cycle memory waits, with a timeout that latches a sticky error.

## Interface
- WAIT_TIMEOUT, 16: maximum consecutive freeze cycles for one memory access before the timeout error; legal range 1..65535.
- CNT_W, 32: width of the performance counters.

- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- Rn_ID  in  5  first source register of the instruction in ID.
- Rm_ID  in  5  second source register of the instruction in ID.
- RnUsed_ID, RmUsed_ID  in  1 each  the ID instruction actually reads Rn/Rm.
- Rd_EX  in  5  destination register of the instruction in EX.
- MemRead_EX  in  1  the instruction in EX is a load.
- BranchTaken_MEM  in  1  branch resolved taken in MEM.
- dmem_req  in  1  MEM-stage instruction is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC register enable.
- IFID_Write  out  1  IF/ID register enable.
- IDEX_Bubble  out  1  load zeros (NOP controls) into ID/EX.
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  clear the respective pipeline register.
- Freeze  out  1  hold every pipeline register and the PC.
- mem_timeout  out  1  sticky error.
- state_o  out  2  FSM state, for debug.
- stall_cycles, freeze_cycles, flush_events  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN=0, MEM_WAIT=1, TIMEOUT=2. Encoding 3 is illegal; it returns to RUN on the next clock.
- Outputs are Mealy: a combinational function of the state and the current inputs.
- Load-use hazard (lu) is true when all of the following hold:
  - MemRead_EX=1;
  - Rd_EX≠31 (XZR is never a hazard);
  - (RnUsed_ID and Rn_ID==Rd_EX) or (RmUsed_ID and Rm_ID==Rd_EX).
- Memory busy (mb) = dmem_req & !dmem_ready.
- Priority in RUN, or in MEM_WAIT when dmem_ready=1:
  1. mb: Freeze=1, PCWrite=0, IFID_Write=0, all flushes and IDEX_Bubble=0.
  2. BranchTaken_MEM: IFID_Flush=IDEX_Flush=EXMEM_Flush=1, PCWrite=1, IFID_Write=1. Any lu is ignored because it belongs to the wrong path.
  3. lu: PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
  4. Otherwise: PCWrite=IFID_Write=1, everything else 0.
- Transitions:
  - RUN, mb: go to MEM_WAIT, wait_cnt←1.
  - MEM_WAIT, dmem_ready=1: go to RUN, wait_cnt←0. Outputs in that cycle follow the priority list above (mb is false).
  - MEM_WAIT, mb and wait_cnt<WAIT_TIMEOUT: wait_cnt+1; outputs as freeze.
  - MEM_WAIT, mb and wait_cnt==WAIT_TIMEOUT: go to TIMEOUT.
  - TIMEOUT: Freeze=1, PCWrite=IFID_Write=0, mem_timeout=1. Held regardless of inputs until reset.
- wait_cnt is $clog2(WAIT_TIMEOUT+1) bits wide and never wraps.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=RUN, wait_cnt=0, mem_timeout=0, counters=0;
  - while reset is high: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, all three flushes=1, Freeze=0, state_o=0.
- Zero-cycle latency from inputs to control outputs. State, wait_cnt and counters update on the rising edge of clk.
- A load-use stall lasts exactly one cycle: the bubble clears MemRead_EX on the next edge.
- Freeze with WAIT_TIMEOUT=N:
  - memory not ready for k cycles: Freeze is high for k cycles when k≤N;
  - mem_timeout rises on edge N+1 if the access is still busy.
- Reset in the middle of MEM_WAIT or TIMEOUT returns to RUN immediately and clears mem_timeout.
- dmem_ready=1 without dmem_req is ignored.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cycles increments each cycle the lu stall path is taken;
  - freeze_cycles increments each cycle Freeze=1 (TIMEOUT included);
  - flush_events increments once per taken-branch flush cycle;
  - all three wrap modulo 2^CNT_W.
- HAZ_PERF_CNT_EN not defined: the counter ports still exist, are tied to 0, and no counter flops are inferred.

## Test plan
- Load-use: MemRead_EX=1, Rd_EX=5, Rn_ID=5, RnUsed_ID=1 for one cycle → PCWrite=0, IFID_Write=0, IDEX_Bubble=1 for 1 cycle; stall_cycles=1.
- XZR and unused operand:
  - Rd_EX=31, Rn_ID=31 → no stall;
  - Rd_EX=7, Rm_ID=7, RmUsed_ID=0 → no stall.
- Branch over a hazard: BranchTaken_MEM=1 together with an active lu → all three flushes=1, PCWrite=1, IDEX_Bubble=0; flush_events=1.
- Memory wait, WAIT_TIMEOUT=4: dmem_req=1, dmem_ready low for 3 cycles then high → Freeze=1 for exactly 3 cycles; state_o goes 1 then back to 0; mem_timeout=0; freeze_cycles=3.
- Timeout, WAIT_TIMEOUT=4: dmem_ready held low → mem_timeout=1 on the 5th edge and state_o=2. Deasserting dmem_req leaves Freeze=1. Pulsing reset mid-cycle clears everything at once.
- Simultaneous events: mb and BranchTaken_MEM in the same cycle → Freeze only, no flush.
  - The flush fires in the cycle dmem_ready=1 if BranchTaken_MEM is still high.
